// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction SRAM controller
package imem_pkg;

    localparam int IMEM_DW    = 32;
    localparam int IMEM_AW    = 8;
    localparam int IMEM_DEPTH = 3;

    typedef struct packed {
        logic [IMEM_DW-1:0] data;
        logic [IMEM_AW-1:0] addr;
    } imem_resp_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_LOAD
    } imem_gnt_e;

    // Response FIFO pointers count 0,1,2 and wrap back to 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/imem_if.sv
// rtl/imem_if.sv - fetch, loader and SRAM port bundle for imem_ctrl
interface imem_if #(
    parameter int DW = 32,
    parameter int AW = 8
) ();
    logic          f_req_valid;
    logic          f_req_ready;
    logic [AW-1:0] f_req_addr;
    logic          f_resp_valid;
    logic          f_resp_ready;
    logic [DW-1:0] f_resp_data;
    logic [AW-1:0] f_resp_addr;
    logic          f_flush;
    logic          l_req_valid;
    logic          l_req_ready;
    logic [AW-1:0] l_req_addr;
    logic [DW-1:0] l_req_data;
    logic          sram_csb0;
    logic          sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;
    logic          busy;

    modport slave (
        input  f_req_valid, f_req_addr, f_resp_ready, f_flush,
        input  l_req_valid, l_req_addr, l_req_data, sram_dout0,
        output f_req_ready, f_resp_valid, f_resp_data, f_resp_addr,
        output l_req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0, busy
    );

    modport master (
        output f_req_valid, f_req_addr, f_resp_ready, f_flush,
        output l_req_valid, l_req_addr, l_req_data, sram_dout0,
        input  f_req_ready, f_resp_valid, f_resp_data, f_resp_addr,
        input  l_req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0, busy
    );
endinterface

// File: rtl/imem_resp_fifo.sv
// rtl/imem_resp_fifo.sv - 3-entry circular response FIFO with flush
module imem_resp_fifo
    import imem_pkg::*;
#(
    parameter int W = IMEM_DW + IMEM_AW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] mem_q [IMEM_DEPTH];
    logic [1:0]   wr_ptr_q;
    logic [1:0]   rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    // Flush wins over both push and pop.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - arbitrates fetch reads and loader writes onto the single-port instruction SRAM
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = IMEM_DW,
    parameter int ADDR_WIDTH = IMEM_AW
) (
    input logic   clk,
    input logic   rst,
    imem_if.slave bus
);

    logic                             s1_valid_q;
    logic [ADDR_WIDTH-1:0]            s1_addr_q;
    logic                             last_q;
    logic [1:0]                       cnt;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] head;
    logic                             f_elig;
    logic                             pop;
    imem_gnt_e                        gnt;

    // Occupancy counts the read in flight so a full FIFO can always absorb it.
    assign f_elig = bus.f_req_valid && (({1'b0, cnt} + {2'b00, s1_valid_q}) < 3'd3);

    always_comb begin
        gnt = GNT_NONE;
        if (rst) begin
            gnt = GNT_NONE;
        end else if (f_elig && bus.l_req_valid) begin
            gnt = last_q ? GNT_FETCH : GNT_LOAD;
        end else if (f_elig) begin
            gnt = GNT_FETCH;
        end else if (bus.l_req_valid) begin
            gnt = GNT_LOAD;
        end
    end

    assign bus.f_req_ready = (gnt == GNT_FETCH);
    assign bus.l_req_ready = (gnt == GNT_LOAD);

    always_comb begin
        bus.sram_csb0  = 1'b1;
        bus.sram_web0  = 1'b1;
        bus.sram_addr0 = '0;
        bus.sram_din0  = '0;
        case (gnt)
            GNT_FETCH: begin
                bus.sram_csb0  = 1'b0;
                bus.sram_addr0 = bus.f_req_addr;
            end
            GNT_LOAD: begin
                bus.sram_csb0  = 1'b0;
                bus.sram_web0  = 1'b0;
                bus.sram_addr0 = bus.l_req_addr;
                bus.sram_din0  = bus.l_req_data;
            end
            default: ;
        endcase
    end

    // A fetch granted alongside a flush survives: it is the redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            last_q     <= 1'b1;
        end else begin
            s1_valid_q <= (gnt == GNT_FETCH);
            if (gnt == GNT_FETCH) begin
                s1_addr_q <= bus.f_req_addr;
            end
            if (gnt != GNT_NONE) begin
                last_q <= (gnt == GNT_LOAD);
            end
        end
    end

    assign pop = bus.f_resp_valid && bus.f_resp_ready;

    // SRAM output is only valid up to just after this edge, so capture it directly.
    imem_resp_fifo #(
        .W(DATA_WIDTH + ADDR_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (s1_valid_q),
        .push_data_i ({bus.sram_dout0, s1_addr_q}),
        .pop_i       (pop),
        .flush_i     (bus.f_flush),
        .head_o      (head),
        .cnt_o       (cnt)
    );

    assign bus.f_resp_valid = (cnt != 2'd0);
    assign {bus.f_resp_data, bus.f_resp_addr} = head;
    assign bus.busy = s1_valid_q || (cnt != 2'd0);

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - randomized self-checking bench for imem_ctrl with SRAM model and scoreboard
module tb_imem_ctrl;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        int          rdy;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    imem_if #(.DW(32), .AW(8)) bus ();

    imem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];
    exp_t        q[$];
    bit          last_m;
    int          cyc;

    // SRAM: registered inputs, data after the falling edge, garbage just after the next rise.
    initial begin : sram_model
        bit         rd_now;
        logic [7:0] rd_a;
        bus.sram_dout0 = '0;
        rd_a = '0;
        forever begin
            @(posedge clk);
            rd_now = 1'b0;
            if (!bus.sram_csb0) begin
                if (!bus.sram_web0) begin
                    sram[bus.sram_addr0] = bus.sram_din0;
                end else begin
                    rd_now = 1'b1;
                    rd_a   = bus.sram_addr0;
                end
            end
            #1 bus.sram_dout0 = $urandom;
            @(negedge clk);
            if (rd_now) bus.sram_dout0 = sram[rd_a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input bit fv, input logic [7:0] fa, input bit lv, input logic [7:0] la,
                        input logic [31:0] ld, input bit rr, input bit fl);
        exp_t e;
        bit   hv, fel, gf, gl;
        bus.f_req_valid  = fv;
        bus.f_req_addr   = fa;
        bus.l_req_valid  = lv;
        bus.l_req_addr   = la;
        bus.l_req_data   = ld;
        bus.f_resp_ready = rr;
        bus.f_flush      = fl;
        #2;
        hv = 1'b0;
        if (q.size() != 0) hv = (q[0].rdy <= cyc);
        fel = fv && (q.size() < 3);
        gf  = fel && (!lv || last_m);
        gl  = lv && !gf;
        chk("f_req_ready", bus.f_req_ready, gf);
        chk("l_req_ready", bus.l_req_ready, gl);
        chk("sram_csb0", bus.sram_csb0, !(gf || gl));
        chk("sram_web0", bus.sram_web0, !gl);
        chk("sram_addr0", bus.sram_addr0, gf ? fa : (gl ? la : 8'h00));
        if (!gf) chk("sram_din0", bus.sram_din0, gl ? ld : 32'h0);
        chk("f_resp_valid", bus.f_resp_valid, hv);
        chk("busy", bus.busy, q.size() != 0);
        if (hv) begin
            chk("f_resp_addr", bus.f_resp_addr, q[0].a);
            chk("f_resp_data", bus.f_resp_data, q[0].d);
        end
        if (fl) q.delete();
        else if (hv && rr) void'(q.pop_front());
        if (gl) ref_mem[la] = ld;
        if (gf) begin
            e.a = fa; e.d = ref_mem[fa]; e.rdy = cyc + 2;
            q.push_back(e);
        end
        if (gf || gl) last_m = gl;
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h0, 0, 8'h0, 32'h0, 1, 0);
    endtask

    initial begin
        logic [31:0] prog [5];
        prog[0] = 32'h003100b3; prog[1] = 32'h40208133; prog[2] = 32'h029301b3;
        prog[3] = 32'h003103b3; prog[4] = 32'h00310333;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        for (int i = 0; i < 5; i++) begin
            sram[i]    = prog[i];
            ref_mem[i] = prog[i];
        end
        clk = 1'b0;
        rst = 1'b1;
        bus.f_req_valid = 1; bus.f_req_addr = 8'h3; bus.l_req_valid = 1; bus.l_req_addr = 8'h4;
        bus.l_req_data = 32'h1; bus.f_resp_ready = 1; bus.f_flush = 0;
        #2;
        chk("rst_f_resp_valid", bus.f_resp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_csb", bus.sram_csb0, 1);
        chk("rst_web", bus.sram_web0, 1);
        chk("rst_f_req_ready", bus.f_req_ready, 0);
        chk("rst_l_req_ready", bus.l_req_ready, 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        q.delete(); last_m = 1'b1; cyc = 0;

        // back-to-back fetch of the preloaded program
        for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 8'h0, 32'h0, 1, 0);
        idle(4);

        // backpressure: three accepts then stall, then drain
        for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 8'h0, 32'h0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h0, 0, 8'h0, 32'h0, 1, 0);

        // async reset between edges with a read in flight
        step(1, 8'h05, 0, 8'h0, 32'h0, 1, 0);
        bus.f_req_valid = 1; bus.l_req_valid = 1;
        rst = 1'b1;
        #1;
        chk("arst_f_resp_valid", bus.f_resp_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_csb", bus.sram_csb0, 1);
        chk("arst_web", bus.sram_web0, 1);
        chk("arst_f_req_ready", bus.f_req_ready, 0);
        chk("arst_l_req_ready", bus.l_req_ready, 0);
        q.delete(); last_m = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        cyc++;
        idle(4);

        // conflict right after reset: F, L, F, L; write 7 then read it back
        step(1, 8'h03, 1, 8'h07, 32'hDEADBEEF, 1, 0);
        step(1, 8'h03, 1, 8'h07, 32'hDEADBEEF, 1, 0);
        step(1, 8'h07, 1, 8'h20, 32'h12345678, 1, 0);
        step(1, 8'h07, 1, 8'h20, 32'h12345678, 1, 0);
        step(1, 8'h07, 0, 8'h00, 32'h0, 1, 0);
        idle(4);

        // flush with queued/in-flight reads, redirect to 0x10
        step(1, 8'h01, 0, 8'h0, 32'h0, 0, 0);
        step(1, 8'h02, 0, 8'h0, 32'h0, 0, 0);
        step(1, 8'h03, 0, 8'h0, 32'h0, 0, 0);
        step(1, 8'h10, 0, 8'h0, 32'h0, 0, 1);
        step(1, 8'h10, 0, 8'h0, 32'h0, 1, 0);
        idle(4);

        // flush in the same cycle a fetch is granted keeps that fetch
        step(1, 8'h04, 0, 8'h0, 32'h0, 0, 0);
        step(1, 8'h11, 0, 8'h0, 32'h0, 0, 1);
        idle(4);

        // random traffic: wrap-around, backpressure, conflicts, occasional flush
        for (int i = 0; i < 120; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
